// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, state encoding and mux/ALU encodings for the multicycle MIPS control.
// CTRL_JUMP_EN adds the JUMP state and makes J/JAL legal.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_RWB    = 4'd7,
    S_EXEC_I = 4'd8,
    S_IWB    = 4'd9,
`ifdef CTRL_JUMP_EN
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
`else
    S_BRANCH = 4'd10
`endif
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  function automatic logic isLegalOp(input logic [5:0] op);
    case (op)
      OP_R, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW: isLegalOp = 1'b1;
`ifdef CTRL_JUMP_EN
      OP_J, OP_JAL: isLegalOp = 1'b1;
`endif
      default: isLegalOp = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from control state (plus live/held opcode and MemReady) to datapath controls.
// CTRL_JUMP_EN enables the JUMP state outputs.
module ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_WIDTH = 3
) (
  input  state_t                 state,
  input  logic [5:0]             op,
  input  logic [5:0]             opHeld,
  input  logic                   memReady,
  input  logic                   resetN,
  output logic                   PCWrite,
  output logic                   BranchEQ,
  output logic                   BranchNE,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   MemtoReg,
  output logic [1:0]             RegDst,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             PCSource,
  output logic [ALUOP_WIDTH-1:0] ALUOp,
  output logic                   IllegalOp
);

  logic [2:0] aluCode;

  always_comb begin
    PCWrite   = 1'b0;
    BranchEQ  = 1'b0;
    BranchNE  = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    MemtoReg  = 1'b0;
    RegDst    = RDST_RT;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RT;
    PCSource  = PCSRC_ALU;
    aluCode   = ALU_ADD;
    IllegalOp = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = memReady;
        PCWrite = memReady;
      end
      S_DECODE: begin
        ALUSrcB   = SRCB_IMMSH2;
        IllegalOp = !isLegalOp(op);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        aluCode = ALU_FUNCT;
      end
      S_RWB: begin
        RegDst   = RDST_RD;
        RegWrite = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        aluCode = (opHeld == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_IWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        aluCode  = ALU_SUB;
        PCSource = PCSRC_ALUOUT;
        BranchEQ = (opHeld == OP_BEQ);
        BranchNE = (opHeld == OP_BNE);
      end
`ifdef CTRL_JUMP_EN
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        if (opHeld == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = RDST_RA;
          ALUSrcB  = SRCB_FOUR;
        end
      end
`endif
      default: ;
    endcase
    // Reset silences every write enable and strobe even though FETCH would raise them.
    if (!resetN) begin
      PCWrite   = 1'b0;
      BranchEQ  = 1'b0;
      BranchNE  = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      IllegalOp = 1'b0;
    end
  end

  assign ALUOp = ALUOP_WIDTH'(aluCode);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control: state register and next-state logic; outputs come from ctrl_decode.
// CTRL_JUMP_EN enables J/JAL through the JUMP state.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             OP,
  input  logic                   MemReady,
  output logic                   PCWrite,
  output logic                   BranchEQ,
  output logic                   BranchNE,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   MemtoReg,
  output logic [1:0]             RegDst,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             PCSource,
  output logic [ALUOP_WIDTH-1:0] ALUOp,
  output logic                   IllegalOp,
  output logic [3:0]             State
);

  state_t     state, stateNext;
  logic [5:0] opHeld;

  always_comb begin
    stateNext = state;
    case (state)
      S_FETCH:  if (MemReady) stateNext = S_DECODE;
      S_DECODE: begin
        case (OP)
          OP_LW, OP_SW:     stateNext = S_MEMADR;
          OP_R:             stateNext = S_EXEC_R;
          OP_ADDI, OP_ORI:  stateNext = S_EXEC_I;
          OP_BEQ, OP_BNE:   stateNext = S_BRANCH;
`ifdef CTRL_JUMP_EN
          OP_J, OP_JAL:     stateNext = S_JUMP;
`endif
          default:          stateNext = S_FETCH;
        endcase
      end
      S_MEMADR: stateNext = (opHeld == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) stateNext = S_MEMWB;
      S_MEMWR:  if (MemReady) stateNext = S_FETCH;
      S_EXEC_R: stateNext = S_RWB;
      S_EXEC_I: stateNext = S_IWB;
      default:  stateNext = S_FETCH;
    endcase
  end

  // OP is only trusted in DECODE; later states steer from the captured copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_FETCH;
      opHeld <= 6'h00;
    end else begin
      state <= stateNext;
      if (state == S_DECODE) opHeld <= OP;
    end
  end

  assign State = state;

  ctrl_decode #(.ALUOP_WIDTH(ALUOP_WIDTH)) uDecode (
    .state    (state),
    .op       (OP),
    .opHeld   (opHeld),
    .memReady (MemReady),
    .resetN   (reset),
    .PCWrite  (PCWrite),
    .BranchEQ (BranchEQ),
    .BranchNE (BranchNE),
    .IorD     (IorD),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .MemtoReg (MemtoReg),
    .RegDst   (RegDst),
    .RegWrite (RegWrite),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .PCSource (PCSource),
    .ALUOp    (ALUOp),
    .IllegalOp(IllegalOp)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle scripts checked every cycle.
// Honors CTRL_JUMP_EN the same way the design does.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam int ALUW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [5:0]      OP;
  logic            MemReady;
  logic            PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic [1:0]      RegDst;
  logic            RegWrite, ALUSrcA;
  logic [1:0]      ALUSrcB, PCSource;
  logic [ALUW-1:0] ALUOp;
  logic            IllegalOp;
  logic [3:0]      State;

  multicycle_control #(.ALUOP_WIDTH(ALUW)) dut (
    .clk(clk), .reset(reset), .OP(OP), .MemReady(MemReady),
    .PCWrite(PCWrite), .BranchEQ(BranchEQ), .BranchNE(BranchNE), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .IllegalOp(IllegalOp), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      st;
    logic            pcw, beq, bne, iord, mrd, mwr, irw, m2r;
    logic [1:0]      rdst;
    logic            rw, sa;
    logic [1:0]      sb, pcs;
    logic [ALUW-1:0] aop;
    logic            ill;
  } obs_t;

  typedef struct packed {
    logic [5:0] iop;
    logic [5:0] drvOp;
    logic       drvMr;
    obs_t       exp;
  } step_t;

  step_t q[$];
  int    nChecks = 0;
  int    nPass   = 0;
  int    cyc     = 0;

  function automatic obs_t mk(input logic [3:0] s);
    obs_t e;
    e    = '0;
    e.st = s;
    return e;
  endfunction

  function automatic obs_t fetchExp(input logic rdy);
    obs_t e;
    e     = mk(S_FETCH);
    e.mrd = 1'b1;
    e.sb  = 2'b01;
    e.irw = rdy;
    e.pcw = rdy;
    return e;
  endfunction

  function automatic logic modelLegal(input logic [5:0] op);
    logic ok;
    ok = op inside {6'h00, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B};
`ifdef CTRL_JUMP_EN
    if (op inside {6'h02, 6'h03}) ok = 1'b1;
`endif
    return ok;
  endfunction

  task automatic add(input logic [5:0] iop, input logic [5:0] o, input logic mr, input obs_t e);
    step_t s;
    s.iop = iop; s.drvOp = o; s.drvMr = mr; s.exp = e;
    q.push_back(s);
  endtask

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Expected per-cycle behaviour for one instruction, built from its opcode and wait counts.
  task automatic genInstr(input logic [5:0] op, input int fw, input int mw);
    obs_t e;
    for (int i = 0; i < fw; i++) add(op, rop(), 1'b0, fetchExp(1'b0));
    add(op, rop(), 1'b1, fetchExp(1'b1));
    e = mk(S_DECODE); e.sb = 2'b11; e.ill = !modelLegal(op);
    add(op, op, rbit(), e);
    if (modelLegal(op)) begin
      if (op == 6'h23 || op == 6'h2B) begin
        e = mk(S_MEMADR); e.sa = 1'b1; e.sb = 2'b10;
        add(op, rop(), rbit(), e);
        if (op == 6'h23) begin
          e = mk(S_MEMRD); e.mrd = 1'b1; e.iord = 1'b1;
        end else begin
          e = mk(S_MEMWR); e.mwr = 1'b1; e.iord = 1'b1;
        end
        for (int i = 0; i < mw; i++) add(op, rop(), 1'b0, e);
        add(op, rop(), 1'b1, e);
        if (op == 6'h23) begin
          e = mk(S_MEMWB); e.rw = 1'b1; e.m2r = 1'b1;
          add(op, rop(), rbit(), e);
        end
      end else if (op == 6'h00) begin
        e = mk(S_EXEC_R); e.sa = 1'b1; e.aop = 7;
        add(op, rop(), rbit(), e);
        e = mk(S_RWB); e.rdst = 2'b01; e.rw = 1'b1;
        add(op, rop(), rbit(), e);
      end else if (op == 6'h08 || op == 6'h0D) begin
        e = mk(S_EXEC_I); e.sa = 1'b1; e.sb = 2'b10; e.aop = (op == 6'h0D) ? 1 : 0;
        add(op, rop(), rbit(), e);
        e = mk(S_IWB); e.rw = 1'b1;
        add(op, rop(), rbit(), e);
      end else if (op == 6'h04 || op == 6'h05) begin
        e = mk(S_BRANCH); e.sa = 1'b1; e.aop = 3; e.pcs = 2'b01;
        e.beq = (op == 6'h04); e.bne = (op == 6'h05);
        add(op, rop(), rbit(), e);
      end else begin
`ifdef CTRL_JUMP_EN
        e = mk(S_JUMP); e.pcw = 1'b1; e.pcs = 2'b10;
        if (op == 6'h03) begin
          e.rw = 1'b1; e.rdst = 2'b10; e.sb = 2'b01;
        end
        add(op, rop(), rbit(), e);
`endif
      end
    end
  endtask

  task automatic chk(input obs_t e, input logic [5:0] iop);
    obs_t got;
    got = '{st: State, pcw: PCWrite, beq: BranchEQ, bne: BranchNE, iord: IorD,
            mrd: MemRead, mwr: MemWrite, irw: IRWrite, m2r: MemtoReg, rdst: RegDst,
            rw: RegWrite, sa: ALUSrcA, sb: ALUSrcB, pcs: PCSource, aop: ALUOp,
            ill: IllegalOp};
    nChecks++;
    assert (got === e) nPass++;
    else $error("FAIL op%02h cyc%0d got=%h exp=%h", iop, cyc, got, e);
  endtask

  task automatic runQueue();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      OP       = s.drvOp;
      MemReady = s.drvMr;
      #2;
      chk(s.exp, s.iop);
      cyc++;
    end
  endtask

  obs_t rstExp;
  logic [5:0] legalOps [9];

  initial begin
    legalOps = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B};
    rstExp   = fetchExp(1'b0);
    rstExp.mrd = 1'b0;

    // Power-on reset with MemReady high: strobes must stay quiet.
    reset = 1'b0; OP = 6'h00; MemReady = 1'b1;
    #3 chk(rstExp, 6'h3F);
    @(negedge clk);
    reset = 1'b1; MemReady = 1'b0;

    genInstr(6'h00, 0, 0);
    genInstr(6'h23, 0, 3);
    genInstr(6'h05, 1, 0);
    genInstr(6'h3F, 0, 0);
    genInstr(6'h03, 0, 0);
    genInstr(6'h2B, 2, 1);
    genInstr(6'h02, 0, 0);
    genInstr(6'h04, 0, 0);
    genInstr(6'h0D, 0, 0);
    genInstr(6'h08, 0, 0);
    runQueue();

    // Reset arriving in the middle of a stalled load.
    add(6'h23, rop(), 1'b1, fetchExp(1'b1));
    begin
      obs_t e;
      e = mk(S_DECODE); e.sb = 2'b11;
      add(6'h23, 6'h23, 1'b0, e);
      e = mk(S_MEMADR); e.sa = 1'b1; e.sb = 2'b10;
      add(6'h23, rop(), 1'b0, e);
      e = mk(S_MEMRD); e.mrd = 1'b1; e.iord = 1'b1;
      add(6'h23, rop(), 1'b0, e);
    end
    runQueue();
    @(negedge clk);
    MemReady = 1'b1; reset = 1'b0;
    #2 chk(rstExp, 6'h23);
    @(negedge clk);
    reset = 1'b1; MemReady = 1'b1;
    #2 chk(fetchExp(1'b1), 6'h23);
    #1 MemReady = 1'b0;

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 4) == 0) ? rop() : legalOps[$urandom_range(0, 8)];
      genInstr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    runQueue();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
